// File: rtl/fetch_unit.sv
// Instruction fetch unit: a single-outstanding-request fetch FSM feeding a
// prefetch FIFO, with branch/jump redirect that flushes the buffer and drops
// any in-flight fetch.
module fetch_unit #(
   parameter int unsigned       ADDR_W   = 32,
   parameter int unsigned       DEPTH    = 4,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_ack,
   input  logic [31:0]       imem_rdata,
   input  logic              br_en,
   input  logic [ADDR_W-1:0] br_pc,
   input  logic [15:0]       br_imm,
   input  logic              jmp_en,
   input  logic [ADDR_W-1:0] jmp_pc,
   input  logic [25:0]       jmp_idx,
   output logic              instr_valid,
   output logic [31:0]       instr,
   output logic [ADDR_W-1:0] instr_pc,
   input  logic              instr_ready
);

   localparam int unsigned       PTR_W   = $clog2(DEPTH);
   localparam int unsigned       CNT_W   = PTR_W + 1;
   localparam logic [CNT_W-1:0]  FULL    = CNT_W'(DEPTH);
   localparam logic [ADDR_W-1:0] LO_MASK = ADDR_W'(28'hFFF_FFFF);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_DROP} state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [ADDR_W-1:0]   r_fetch_pc;
   logic [ADDR_W-1:0]   r_addr;
   logic                r_req;
   logic [CNT_W-1:0]    r_count;
   logic [PTR_W-1:0]    r_head;
   logic [PTR_W-1:0]    r_tail;
   logic [31:0]         r_data [DEPTH];
   logic [ADDR_W-1:0]   r_pc   [DEPTH];

   logic [ADDR_W-1:0]   w_br_sext;
   logic [ADDR_W-1:0]   w_br_tgt;
   logic [ADDR_W-1:0]   w_jmp_seq;
   logic [ADDR_W-1:0]   w_jmp_tgt;
   logic [ADDR_W-1:0]   w_tgt;
   logic                w_redir;
   logic                w_push;
   logic                w_pop;
   logic [CNT_W-1:0]    w_count_nxt;
   logic [ADDR_W-1:0]   w_fetch_pc_nxt;

   // Redirect targets; jump wins when both are raised
   assign w_br_sext = {{(ADDR_W-16){br_imm[15]}}, br_imm};
   assign w_br_tgt  = br_pc + ADDR_W'(4) + (w_br_sext << 2);
   assign w_jmp_seq = jmp_pc + ADDR_W'(4);
   assign w_jmp_tgt = (w_jmp_seq & ~LO_MASK) | ADDR_W'({jmp_idx, 2'b00});
   assign w_redir   = br_en | jmp_en;
   assign w_tgt     = jmp_en ? w_jmp_tgt : w_br_tgt;

   // Buffer push/pop qualification; a redirect discards both
   assign w_push = (r_state == S_REQ) && imem_ack && !w_redir && (r_count != FULL);
   assign w_pop  = instr_valid && instr_ready && !w_redir;

   assign w_count_nxt    = w_redir ? '0 : (r_count + CNT_W'(w_push) - CNT_W'(w_pop));
   assign w_fetch_pc_nxt = w_redir ? w_tgt :
                           (w_push ? (r_fetch_pc + ADDR_W'(4)) : r_fetch_pc);

   // Fetch FSM state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= S_IDLE;
      else      r_state <= w_state_nxt;
   end

   // Fetch FSM next-state
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (!w_redir && (r_count < FULL)) w_state_nxt = S_REQ;
         end
         S_REQ: begin
            if (imem_ack) begin
               if (w_redir || (w_count_nxt < FULL)) w_state_nxt = S_REQ;
               else                                 w_state_nxt = S_IDLE;
            end else if (w_redir) begin
               w_state_nxt = S_DROP;
            end
         end
         S_DROP: begin
            if (imem_ack) w_state_nxt = S_REQ;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Fetch PC, registered request outputs and the prefetch FIFO
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_fetch_pc <= RESET_PC;
         r_addr     <= RESET_PC;
         r_req      <= 1'b0;
         r_count    <= '0;
         r_head     <= '0;
         r_tail     <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            r_data[PTR_W'(i)] <= '0;
            r_pc[PTR_W'(i)]   <= '0;
         end
      end else begin
         r_fetch_pc <= w_fetch_pc_nxt;
         r_count    <= w_count_nxt;
         r_req      <= (w_state_nxt != S_IDLE);
         // address only moves when a fresh request starts; DROP keeps the stale one
         if (w_state_nxt == S_REQ) r_addr <= w_fetch_pc_nxt;
         if (w_redir) begin
            r_head <= '0;
            r_tail <= '0;
         end else begin
            if (w_push) begin
               r_data[r_tail] <= imem_rdata;
               r_pc[r_tail]   <= r_fetch_pc;
               r_tail         <= r_tail + PTR_W'(1);
            end
            if (w_pop) r_head <= r_head + PTR_W'(1);
         end
      end
   end

   assign imem_req    = r_req;
   assign imem_addr   = r_addr;
   assign instr_valid = (r_count != '0);
   assign instr       = r_data[r_head];
   assign instr_pc    = r_pc[r_head];

endmodule
